// File: rtl/vending_pkg.sv
// Shared coin codes, coin values and change-dispenser FSM state type.
package vending_pkg;

  localparam int unsigned AMT_W  = 6;
  localparam int unsigned COIN_W = 2;

  typedef enum logic [COIN_W-1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_e;

  // Coin values in nickel units
  localparam logic [AMT_W-1:0] VAL_NICKEL  = 6'd1;
  localparam logic [AMT_W-1:0] VAL_DIME    = 6'd2;
  localparam logic [AMT_W-1:0] VAL_QUARTER = 6'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // Value of a coin code in nickel units
  function automatic logic [AMT_W-1:0] coin_value(input coin_e c);
    logic [AMT_W-1:0] v;
    case (c)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest stocked coin not exceeding the remaining amount.
// Quarters take part only when CHANGE_QUARTER_EN is defined.
module coin_select
  import vending_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [CNT_W-1:0] nickel_cnt,
  input  logic [CNT_W-1:0] dime_cnt,
`ifdef CHANGE_QUARTER_EN
  input  logic [CNT_W-1:0] quarter_cnt,
`endif
  output coin_e            code_c,
  output logic             found_c
);

  // Later assignments win, so the largest qualifying coin is chosen
  always_comb begin
    code_c = COIN_NONE;
    if (remaining >= VAL_NICKEL && nickel_cnt != '0) code_c = COIN_NICKEL;
    if (remaining >= VAL_DIME && dime_cnt != '0)     code_c = COIN_DIME;
`ifdef CHANGE_QUARTER_EN
    if (remaining >= VAL_QUARTER && quarter_cnt != '0) code_c = COIN_QUARTER;
`endif
  end

  assign found_c = (code_c != COIN_NONE);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount coin by coin from a saturating
// inventory. Define CHANGE_QUARTER_EN to add a quarter inventory.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned NICKEL_INIT = 4,
  parameter int unsigned DIME_INIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [AMT_W-1:0]  req_amount,
  output logic              req_ready,
  output logic [COIN_W-1:0] coin,
  output logic              coin_valid,
  input  logic              coin_ready,
  input  logic              refill_valid,
  input  logic [COIN_W-1:0] refill_coin,
  output logic              done,
  output logic              err,
  output logic [AMT_W-1:0]  short_amt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state, state_d;
  logic [AMT_W-1:0]  remaining;
  logic [CNT_W-1:0]  nickel_cnt, dime_cnt;
`ifdef CHANGE_QUARTER_EN
  logic [CNT_W-1:0]  quarter_cnt;
`endif
  coin_e             coin_q, coin_d, sel_code;
  logic              sel_found;
  logic              accept, handshake;
  logic              req_ready_d, coin_valid_d, done_d, err_d;
  logic [AMT_W-1:0]  short_amt_d;

  assign accept    = req_valid && req_ready;
  assign handshake = coin_valid && coin_ready;
  assign coin      = COIN_W'(coin_q);

  // Saturating add on refill, decrement on dispense, hold when both coincide
  function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != CNT_MAX) r = cnt + CNT_W'(1);
    else if (dec && !inc)               r = cnt - CNT_W'(1);
    return r;
  endfunction

  coin_select #(.CNT_W(CNT_W)) u_coin_select (
    .remaining   (remaining),
    .nickel_cnt  (nickel_cnt),
    .dime_cnt    (dime_cnt),
`ifdef CHANGE_QUARTER_EN
    .quarter_cnt (quarter_cnt),
`endif
    .code_c      (sel_code),
    .found_c     (sel_found)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (accept) state_d = ST_SELECT;
      ST_SELECT: begin
        if (remaining == '0) state_d = ST_DONE;
        else if (sel_found)  state_d = ST_PRESENT;
        else                 state_d = ST_ERROR;
      end
      ST_PRESENT: if (handshake) state_d = ST_SELECT;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERROR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode for the upcoming state; coin is captured on entry to PRESENT
  always_comb begin
    req_ready_d  = 1'b0;
    coin_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    short_amt_d  = '0;
    coin_d       = COIN_NONE;
    case (state_d)
      ST_IDLE:    req_ready_d = 1'b1;
      ST_PRESENT: begin
        coin_valid_d = 1'b1;
        coin_d       = (state == ST_SELECT) ? sel_code : coin_q;
      end
      ST_DONE:    done_d = 1'b1;
      ST_ERROR: begin
        err_d       = 1'b1;
        short_amt_d = remaining;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready  <= 1'b1;
      coin_valid <= 1'b0;
      coin_q     <= COIN_NONE;
      done       <= 1'b0;
      err        <= 1'b0;
      short_amt  <= '0;
    end else begin
      req_ready  <= req_ready_d;
      coin_valid <= coin_valid_d;
      coin_q     <= coin_d;
      done       <= done_d;
      err        <= err_d;
      short_amt  <= short_amt_d;
    end
  end

  // Amount still owed: loaded on accept, reduced on each coin handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         remaining <= '0;
    else if (accept)    remaining <= req_amount;
    else if (handshake) remaining <= remaining - coin_value(coin_q);
  end

  // Coin inventories
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nickel_cnt  <= CNT_W'(NICKEL_INIT);
      dime_cnt    <= CNT_W'(DIME_INIT);
`ifdef CHANGE_QUARTER_EN
      quarter_cnt <= '0;
`endif
    end else begin
      nickel_cnt  <= inv_next(nickel_cnt, refill_valid && refill_coin == COIN_NICKEL,
                              handshake && coin_q == COIN_NICKEL);
      dime_cnt    <= inv_next(dime_cnt, refill_valid && refill_coin == COIN_DIME,
                              handshake && coin_q == COIN_DIME);
`ifdef CHANGE_QUARTER_EN
      quarter_cnt <= inv_next(quarter_cnt, refill_valid && refill_coin == COIN_QUARTER,
                              handshake && coin_q == COIN_QUARTER);
`endif
    end
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter CNT_W, default 4, meaning width of each coin inventory counter.
REQ-002 SHALL have parameter NICKEL_INIT, default 4, meaning nickel inventory loaded at reset.
REQ-003 SHALL have parameter DIME_INIT, default 4, meaning dime inventory loaded at reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  change request present.
REQ-007 SHALL have port req_amount  input  6  change owed, in nickel units (5c).
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port coin  output  2  coin code: 0 none, 1 nickel, 2 dime, 3 quarter; same coding the vending machine consumes.
REQ-010 SHALL have port coin_valid  output  1  coin is being presented to the ejector.
REQ-011 SHALL have port coin_ready  input  1  ejector took the coin.
REQ-012 SHALL have port refill_valid  input  1  one coin added to inventory this cycle.
REQ-013 SHALL have port refill_coin  input  2  code of the refilled coin.
REQ-014 SHALL have port done  output  1  one-cycle pulse: request fully paid.
REQ-015 SHALL have port err  output  1  one-cycle pulse: request aborted, insufficient inventory.
REQ-016 SHALL have port short_amt  output  6  unpaid remainder, valid in the err cycle, else 0.

Function
REQ-017 SHALL implement FSM IDLE, SELECT, PRESENT, DONE, ERROR.
REQ-018 SHALL assert req_ready only in IDLE; on req_valid&&req_ready latch req_amount into remaining and go to SELECT.
REQ-019 SHALL, in SELECT, pick the largest enabled coin with value <= remaining and nonzero inventory (quarter 5, dime 2, nickel 1), register it on coin, and go to PRESENT.
REQ-020 SHALL go from SELECT to DONE when remaining==0 (including req_amount 0), and to ERROR when remaining>0 and no coin qualifies.
REQ-021 SHALL hold coin_valid=1 and coin stable throughout PRESENT until coin_ready=1.
REQ-022 SHALL, on coin_valid&&coin_ready, subtract the coin value from remaining, decrement that inventory, and return to SELECT; first coin_valid no earlier than 2 cycles after request acceptance.
REQ-023 SHALL pulse done for one cycle in DONE, and err plus short_amt=remaining for one cycle in ERROR, then return to IDLE.
REQ-024 SHALL add refills in any state, saturating at 2^CNT_W-1; refill_coin 0 (or 3 when quarters disabled) SHALL be ignored.
REQ-025 SHALL leave an inventory unchanged when a refill and a dispense of the same coin coincide.
REQ-026 SHALL drive coin=0 whenever coin_valid=0.

Reset
REQ-027 SHALL, on reset low, immediately enter IDLE, clear remaining, coin, coin_valid, done, err, short_amt, and load inventories from NICKEL_INIT/DIME_INIT (quarters 0); any in-progress request is discarded.
REQ-028 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with CHANGE_QUARTER_EN defined, add a quarter inventory counter (reset 0, refill code 3) and quarters in the REQ-019 selection.
REQ-030 SHALL, without CHANGE_QUARTER_EN, omit the quarter counter and never emit code 3.

Structure
REQ-031 SHALL take coin codes, coin values, and FSM state typedef from shared package vending_pkg.
REQ-032 SHALL place the greedy selection in combinational sub-module coin_select (inputs remaining + inventories, outputs code + found flag).

Verification
REQ-033 SHALL cover: reset low mid-PRESENT -> next cycle coin_valid=0, req_ready=1 after release, inventories 4/4.
REQ-034 SHALL cover: amount 3, coin_ready=1 -> coin 2 then coin 1, then done pulse; nickel=3, dime=3.
REQ-035 SHALL cover: amount 2, coin_ready low 5 cycles -> coin=2 held stable with coin_valid=1 for all 5, one dime consumed.
REQ-036 SHALL cover: nickel inventory 0, dime 4, amount 3 -> dime dispensed, then err pulse with short_amt=1.
REQ-037 SHALL cover: refill nickel concurrently with nickel handshake -> nickel count unchanged; 20 refills at CNT_W=4 -> saturates at 15.
REQ-038 SHALL cover (CHANGE_QUARTER_EN, 1 quarter refilled): amount 7 -> coin 3 then coin 2, done pulse.
